alu_sequencer: RTL

Hardwired control sequencer that drives the datapath's fetch and register-to-register ALU steps (T0–T5) autonomously, replacing hand-sequenced control strobes. Decodes the instruction register, generates one-hot register-file select vectors and an ALU opcode, and supports a memory-wait handshake. Sits between the memory interface and the DataPath control inputs; parametrised in data width, register count and opcode field width.

---
 rtl/alu_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: hardwired T0..T5 control sequencer for the fetch and
// register-to-register ALU steps of the datapath.
// Decodes the instruction register and emits Moore-style control strobes,
// one-hot register select vectors and an ALU opcode.
// Optional feature macro: MEM_WAIT_EN. When defined, T1 stalls until
// i_mem_ready is high. When undefined, i_mem_ready is ignored.
module alu_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_COUNT    = 16,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                  i_clock,
    input  logic                  i_clear,
    input  logic                  i_run,
    input  logic                  i_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_ir,
    output logic                  o_PCout,
    output logic                  o_Zlowout,
    output logic                  o_MDRout,
    output logic                  o_PCin,
    output logic                  o_MARin,
    output logic                  o_MDRin,
    output logic                  o_IRin,
    output logic                  o_Yin,
    output logic                  o_Zin,
    output logic                  o_IncPC,
    output logic                  o_Read,
    output logic [REG_COUNT-1:0]  o_Rin,
    output logic [REG_COUNT-1:0]  o_Rout,
    output logic [3:0]            o_alu_op,
    output logic                  o_done,
    output logic                  o_halted,
    output logic                  o_illegal
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    // Register indices are always 4 bits wide; REG_COUNT may be smaller,
    // so indices at or above REG_LIMIT are rejected as illegal.
    localparam int         RIDX_W    = 4;
    localparam logic [4:0] REG_LIMIT = 5'(REG_COUNT);

    localparam logic [OPCODE_WIDTH-1:0] OP_FIRST_ALU = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_LAST_ALU  = OPCODE_WIDTH'(10);

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic                    r_illegal;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [RIDX_W-1:0]       w_ra;
    logic [RIDX_W-1:0]       w_rb;
    logic [RIDX_W-1:0]       w_rc;
    logic                    w_is_alu;
    logic                    w_is_halt;
    logic                    w_regs_ok;
    logic                    w_legal_alu;
    logic [REG_COUNT-1:0]    w_ra_hot;
    logic [REG_COUNT-1:0]    w_rb_hot;
    logic [REG_COUNT-1:0]    w_rc_hot;
    logic                    w_unused;

    // Instruction fields: opcode at the top, then Ra, Rb, Rc.
    assign w_opcode = i_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign w_ra     = i_ir[DATA_WIDTH-OPCODE_WIDTH-1 -: RIDX_W];
    assign w_rb     = i_ir[DATA_WIDTH-OPCODE_WIDTH-RIDX_W-1 -: RIDX_W];
    assign w_rc     = i_ir[DATA_WIDTH-OPCODE_WIDTH-2*RIDX_W-1 -: RIDX_W];

    // Halt is the all-ones opcode; ALU ops occupy the contiguous range 3..10.
    assign w_is_halt   = &w_opcode;
    assign w_is_alu    = (w_opcode >= OP_FIRST_ALU) && (w_opcode <= OP_LAST_ALU);
    assign w_regs_ok   = ({1'b0, w_ra} < REG_LIMIT) &&
                         ({1'b0, w_rb} < REG_LIMIT) &&
                         ({1'b0, w_rc} < REG_LIMIT);
    assign w_legal_alu = w_is_alu && w_regs_ok;

    // Low instruction bits (immediate field) are not used by this sequencer;
    // mem_ready is only consulted when the wait handshake is compiled in.
    assign w_unused = ^{i_ir, i_mem_ready};

    // One-hot select decoders; an out-of-range index simply yields all zeros.
    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_sel
            assign w_ra_hot[gi] = (w_ra == RIDX_W'(gi));
            assign w_rb_hot[gi] = (w_rb == RIDX_W'(gi));
            assign w_rc_hot[gi] = (w_rc == RIDX_W'(gi));
        end
    endgenerate

    // State register and sticky illegal flag; clear aborts asynchronously.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_T3 && !w_is_halt && !w_legal_alu) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state logic; run is only looked at in IDLE and T5.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = i_run ? S_T0 : S_IDLE;
            S_T0:   w_state_next = S_T1;
`ifdef MEM_WAIT_EN
            S_T1:   w_state_next = i_mem_ready ? S_T2 : S_T1;
`else
            S_T1:   w_state_next = S_T2;
`endif
            S_T2:   w_state_next = S_T3;
            S_T3:   w_state_next = w_legal_alu ? S_T4 : S_HALT;
            S_T4:   w_state_next = S_T5;
            S_T5:   w_state_next = i_run ? S_T0 : S_IDLE;
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Moore strobe decode from the state; T3 is additionally gated by decode.
    always_comb begin
        o_PCout   = 1'b0;
        o_Zlowout = 1'b0;
        o_MDRout  = 1'b0;
        o_PCin    = 1'b0;
        o_MARin   = 1'b0;
        o_MDRin   = 1'b0;
        o_IRin    = 1'b0;
        o_Yin     = 1'b0;
        o_Zin     = 1'b0;
        o_IncPC   = 1'b0;
        o_Read    = 1'b0;
        o_Rin     = '0;
        o_Rout    = '0;
        o_alu_op  = 4'd0;
        o_done    = 1'b0;
        o_halted  = 1'b0;
        case (r_state)
            S_T0: begin
                o_PCout = 1'b1;
                o_MARin = 1'b1;
                o_IncPC = 1'b1;
                o_Zin   = 1'b1;
            end
            S_T1: begin
                o_Zlowout = 1'b1;
                o_PCin    = 1'b1;
                o_Read    = 1'b1;
                o_MDRin   = 1'b1;
            end
            S_T2: begin
                o_MDRout = 1'b1;
                o_IRin   = 1'b1;
            end
            S_T3: begin
                if (w_legal_alu) begin
                    o_Rout = w_rb_hot;
                    o_Yin  = 1'b1;
                end
            end
            S_T4: begin
                o_Rout   = w_rc_hot;
                o_alu_op = w_opcode[3:0];
                o_Zin    = 1'b1;
            end
            S_T5: begin
                o_Zlowout = 1'b1;
                o_Rin     = w_ra_hot;
                o_done    = 1'b1;
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_illegal = r_illegal;

endmodule
